// File: rtl/demux_rr_feeder_if.sv
// Handshake/bus bundle between the byte source, the round-robin feeder
// and the sinks behind the 1-to-NCH demux.
interface demux_rr_feeder_if #(
   parameter int WIDTH = 8,
   parameter int SNUM  = 4
);
   localparam int NCH = 2 ** SNUM;

   logic             en;
   logic [NCH-1:0]   ch_mask;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [NCH-1:0]   ch_ready;
   logic [WIDTH-1:0] out_data;
   logic [SNUM-1:0]  out_sel;
   logic             out_valid;
   logic             burst_done;

   // source / sink side
   modport master (
      output en, ch_mask, in_data, in_valid, ch_ready,
      input  in_ready, out_data, out_sel, out_valid, burst_done
   );

   // feeder side
   modport slave (
      input  en, ch_mask, in_data, in_valid, ch_ready,
      output in_ready, out_data, out_sel, out_valid, burst_done
   );
endinterface

// File: rtl/demux_rr_feeder.sv
// Round-robin burst feeder for the 1-to-NCH demux. Bytes accepted on a
// valid/ready handshake are sent in bursts of BURST_LEN to one enabled
// channel at a time; the selected sink's ready throttles the stream.
module demux_rr_feeder #(
   parameter int WIDTH     = 8,
   parameter int SNUM      = 4,
   parameter int BURST_LEN = 4
) (
   input logic             clk,
   input logic             rst_n,
   demux_rr_feeder_if.slave bus
);
   localparam int NCH = 2 ** SNUM;
   localparam int CW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t          state, nstate;
   logic [SNUM-1:0] ptr;
   logic [SNUM-1:0] cur_ch;
   logic [CW-1:0]   beat_cnt;
   logic [SNUM-1:0] hit_ch;
   logic [SNUM-1:0] idx;
   logic            hit;
   logic            lock;
   logic            acc;
   logic            last;

   // Find the first enabled channel at or after ptr, wrapping mod NCH.
   // Descending scan so the smallest offset from ptr is written last.
   always_comb begin
      hit    = 1'b0;
      hit_ch = '0;
      idx    = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = ptr + SNUM'(i);
         if (bus.ch_mask[idx]) begin
            hit    = 1'b1;
            hit_ch = idx;
         end
      end
   end

   assign lock = (state == IDLE) && bus.en && hit;
   assign acc  = bus.in_valid && bus.in_ready;
   assign last = (beat_cnt == CW'(BURST_LEN - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   // Next state: a burst starts from IDLE when enabled with a live mask and
   // ends on its final accept, leaving one IDLE cycle between bursts.
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (lock) nstate = BURST;
         BURST:   if (acc && last) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Output decode: accept only inside a burst when the output slot is free
   // or is being drained by the selected sink this cycle.
   always_comb begin
      bus.in_ready = (state == BURST) && (!bus.out_valid || bus.ch_ready[bus.out_sel]);
   end

   // Channel lock, beat counting and round-robin pointer advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         cur_ch   <= '0;
         beat_cnt <= '0;
      end else begin
         if (lock) begin
            cur_ch   <= hit_ch;
            beat_cnt <= '0;
         end else if (acc) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last) ptr <= cur_ch + 1'b1;
         end
      end
   end

   // Output register: a new byte overwrites a taken one with no bubble;
   // a taken byte with nothing behind it empties the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_data   <= '0;
         bus.out_sel    <= '0;
         bus.out_valid  <= 1'b0;
         bus.burst_done <= 1'b0;
      end else begin
         bus.burst_done <= acc && last;
         if (acc) begin
            bus.out_data  <= bus.in_data;
            bus.out_sel   <= cur_ch;
            bus.out_valid <= 1'b1;
         end else if (bus.out_valid && bus.ch_ready[bus.out_sel]) begin
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_demux_rr_feeder.sv
// Directed + randomized bench for demux_rr_feeder against a burst-level
// reference model (channel choice by mask search, beat counting per burst).
module tb_demux_rr_feeder;
   localparam int WIDTH = 8;
   localparam int SNUM  = 4;
   localparam int NCH   = 16;
   localparam int BL    = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   demux_rr_feeder_if #(.WIDTH(WIDTH), .SNUM(SNUM)) bus ();

   demux_rr_feeder #(.WIDTH(WIDTH), .SNUM(SNUM), .BURST_LEN(BL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int total  = 0;
   int passed = 0;

   // reference model state
   int mptr = 0;
   int mcnt = 0;
   int mch  = 0;
   bit idle_next = 1'b0;
   int acc_cnt = 0;
   int done_cnt = 0;
   int ov_cnt = 0;
   bit last_acc = 1'b0;
   bit last_tk = 1'b0;
   int burst_ch[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int first_from(input logic [NCH-1:0] m, input int p);
      for (int i = 0; i < NCH; i++)
         if (m[(p + i) % NCH]) return (p + i) % NCH;
      return -1;
   endfunction

   // One clock: sample handshake mid-cycle, then check the registered result.
   task automatic step();
      logic ir, ov, tk, a;
      logic [WIDTH-1:0] od, pd;
      logic [SNUM-1:0] os;
      logic [NCH-1:0] pm;
      #4;
      ir = bus.in_ready; ov = bus.out_valid; od = bus.out_data; os = bus.out_sel;
      pd = bus.in_data;  pm = bus.ch_mask;
      a  = bus.in_valid & ir;
      tk = ov & bus.ch_ready[os];
      if (ov && !bus.ch_ready[os]) chk("stall_in_ready", {31'd0, ir}, 32'd0);
      if (idle_next) begin
         chk("gap_in_ready", {31'd0, ir}, 32'd0);
         idle_next = 1'b0;
      end
      if (ov) ov_cnt++;
      @(posedge clk); #1;
      last_acc = a; last_tk = tk;
      if (a) begin
         if (mcnt == 0) begin
            mch = first_from(pm, mptr);
            burst_ch.push_back(mch);
         end
         acc_cnt++; mcnt++;
         chk("acc_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("acc_data", {24'd0, bus.out_data}, {24'd0, pd});
         chk("acc_sel", {28'd0, bus.out_sel}, mch);
         chk("burst_done", {31'd0, bus.burst_done}, (mcnt == BL) ? 32'd1 : 32'd0);
         if (mcnt == BL) begin
            mptr = (mch + 1) % NCH; mcnt = 0; idle_next = 1'b1; done_cnt++;
         end
      end else if (tk) begin
         chk("taken_valid", {31'd0, bus.out_valid}, 32'd0);
         chk("taken_data", {24'd0, bus.out_data}, 32'd0);
         chk("taken_sel", {28'd0, bus.out_sel}, {28'd0, os});
         chk("taken_done", {31'd0, bus.burst_done}, 32'd0);
      end else begin
         chk("hold_valid", {31'd0, bus.out_valid}, {31'd0, ov});
         chk("hold_data", {24'd0, bus.out_data}, {24'd0, od});
         chk("hold_sel", {28'd0, bus.out_sel}, {28'd0, os});
         chk("hold_done", {31'd0, bus.burst_done}, 32'd0);
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
      chk({tag, "_data"}, {24'd0, bus.out_data}, 32'd0);
      chk({tag, "_sel"}, {28'd0, bus.out_sel}, 32'd0);
      chk({tag, "_done"}, {31'd0, bus.burst_done}, 32'd0);
      chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [WIDTH-1:0] held;
      bit switched;
      int exp3[7];
      exp3 = '{0, 2, 15, 0, 2, 4, 4};

      // T1: reset with traffic offered
      bus.en = 1'b1; bus.ch_mask = 16'hFFFF; bus.ch_ready = 16'hFFFF;
      bus.in_data = 8'h00; bus.in_valid = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk_cleared("t1_reset");
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // T2: full mask, always ready, bytes 0x00..0x3F
      bus.in_data = 8'h00; ov_cnt = 0; acc_cnt = 0; done_cnt = 0; burst_ch.delete();
      for (int i = 0; i < 400 && acc_cnt < 64; i++) begin
         step();
         if (last_acc) bus.in_data = bus.in_data + 8'd1;
      end
      bus.en = 1'b0; bus.in_valid = 1'b0;
      repeat (3) step();
      chk("t2_accepts", acc_cnt, 64);
      chk("t2_valid_cycles", ov_cnt, 64);
      chk("t2_bursts", done_cnt, 16);
      for (int i = 0; i < 16; i++)
         chk("t2_order", (i < burst_ch.size()) ? burst_ch[i] : -1, i);

      // T3: masked skip + wrap, mask swapped mid-burst
      burst_ch.delete(); switched = 1'b0;
      bus.ch_mask = 16'h8005; bus.en = 1'b1; bus.in_valid = 1'b1;
      for (int i = 0; i < 200 && !(burst_ch.size() == 7 && mcnt == 0); i++) begin
         step();
         if (last_acc) bus.in_data = 8'($urandom);
         if (!switched && burst_ch.size() == 5 && mcnt == 2) begin
            bus.ch_mask = 16'h0010; switched = 1'b1;
         end
      end
      bus.en = 1'b0; bus.in_valid = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 7; i++)
         chk("t3_order", (i < burst_ch.size()) ? burst_ch[i] : -1, exp3[i]);

      // T4: channel 2 stalls for 5 cycles mid-burst
      bus.ch_mask = 16'h0004; bus.en = 1'b1; bus.in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         if (last_acc) bus.in_data = 8'($urandom);
         if (bus.out_valid && bus.out_sel == 4'd2 && mcnt != 0) break;
      end
      chk("t4_reached", {31'd0, bus.out_valid}, 32'd1);
      held = bus.out_data; base = acc_cnt;
      bus.ch_ready = 16'hFFFB;
      repeat (5) step();
      chk("t4_held_data", {24'd0, bus.out_data}, {24'd0, held});
      chk("t4_held_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t4_no_accept", acc_cnt - base, 0);
      bus.ch_ready = 16'hFFFF;
      step();
      chk("t4_release", {31'd0, last_acc & last_tk}, 32'd1);
      if (last_acc) bus.in_data = 8'($urandom);

      // T5: en dropped mid-burst, then empty mask
      bus.en = 1'b0;
      for (int i = 0; i < 50 && mcnt != 0; i++) begin
         step();
         if (last_acc) bus.in_data = 8'($urandom);
      end
      chk("t5_burst_complete", mcnt, 0);
      base = acc_cnt;
      repeat (20) step();
      chk("t5_en0_no_accept", acc_cnt - base, 0);
      chk("t5_en0_ready", {31'd0, bus.in_ready}, 32'd0);
      bus.ch_mask = 16'h0000; bus.en = 1'b1;
      repeat (20) step();
      chk("t5_mask0_no_accept", acc_cnt - base, 0);
      chk("t5_mask0_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t5_drained", {31'd0, bus.out_valid}, 32'd0);

      // T6: async reset after 2 of 4 bytes
      bus.ch_mask = 16'hFFFF;
      for (int i = 0; i < 50 && mcnt != 2; i++) begin
         step();
         if (last_acc) bus.in_data = 8'($urandom);
      end
      chk("t6_mid_burst", mcnt, 2);
      #2 rst_n = 1'b0;
      #1 chk_cleared("t6_async");
      mptr = 0; mcnt = 0; idle_next = 1'b0;
      @(posedge clk); #1;
      chk_cleared("t6_held");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      burst_ch.delete();
      for (int i = 0; i < 50 && burst_ch.size() == 0; i++) begin
         step();
         if (last_acc) bus.in_data = 8'($urandom);
      end
      chk("t6_restart_ch0", (burst_ch.size() > 0) ? burst_ch[0] : -1, 0);

      // T7: random traffic, sink stalls and mid-burst mask changes
      for (int i = 0; i < 400; i++) begin
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.in_data  = 8'($urandom);
         bus.ch_ready = 16'($urandom) | 16'($urandom);
         bus.en       = ($urandom_range(0, 7) != 0);
         if (mcnt != 0 && $urandom_range(0, 9) == 0)
            bus.ch_mask = 16'($urandom_range(1, 65535));
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
